// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and
// data load/store. Data normally wins contention, but fetch is forced after
// MAX_DSTREAK consecutive data grants while a fetch is waiting. A grant is
// held until the RAM completes it (ACCESS), fails it (ERROR), or the grant
// times out. ERROR and timeout end the grant with zero load data and a
// memerr pulse.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [ADDR_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic [ADDR_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr
);

    localparam int STREAK_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam int TCNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t              state_q;
    logic [STREAK_W-1:0] dstreak_q;
    logic [TCNT_W-1:0]   tcnt_q;

    logic                d_req;
    logic                i_live;
    logic                d_live;
    logic                live;
    logic                rs_access;
    logic                rs_error;
    logic                tmo;
    logic                fail;
    logic                done;
    logic                fetch_forced;
    logic [STREAK_W-1:0] dstreak_inc_d;

    // Grant qualification and completion decode. A grant only counts while
    // its request is still asserted, so a dropped request silently aborts
    // (no completion, no error). A timeout fires on the grant cycle that
    // would bring tcnt up to TIMEOUT without the RAM having answered.
    always_comb begin
        d_req        = dREN | dWEN;
        i_live       = (state_q == IGRANT) && iREN;
        d_live       = (state_q == DGRANT) && d_req;
        live         = i_live | d_live;
        rs_access    = (ramstate == RS_ACCESS);
        rs_error     = (ramstate == RS_ERROR);
        tmo          = !rs_access && !rs_error && (tcnt_q == TCNT_W'(TIMEOUT - 1));
        fail         = live && (rs_error || tmo);
        done         = live && (rs_access || rs_error || tmo);
        fetch_forced = iREN && (dstreak_q >= STREAK_W'(MAX_DSTREAK));
        dstreak_inc_d = (dstreak_q >= STREAK_W'(MAX_DSTREAK)) ? dstreak_q
                                                              : dstreak_q + 1'b1;
    end

    // RAM-side and requester-side outputs, combinational from state and
    // ramstate so a completing access is visible in the same cycle. Write
    // takes precedence over read when both data enables are high.
    always_comb begin
        ramREN   = i_live | (d_live & ~dWEN);
        ramWEN   = d_live & dWEN;
        ramaddr  = i_live ? iaddr : (d_live ? daddr : '0);
        ramstore = (d_live & dWEN) ? dstore : '0;
        iload    = (i_live & rs_access) ? ramload : '0;
        dload    = (d_live & ~dWEN & rs_access) ? ramload : '0;
        iwait    = iREN & ~(i_live & done);
        dwait    = d_req & ~(d_live & done);
        memerr   = fail;
    end

    // Arbitration FSM with data-streak and grant-timeout bookkeeping. tcnt is
    // cleared in IDLE, which every grant is entered from.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            tcnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (d_req && !fetch_forced) begin
                        state_q <= DGRANT;
                    end else if (iREN) begin
                        state_q <= IGRANT;
                    end
                end
                IGRANT: begin
                    if (!iREN) begin
                        state_q <= IDLE;
                    end else if (done) begin
                        state_q   <= IDLE;
                        dstreak_q <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                DGRANT: begin
                    if (!d_req) begin
                        state_q <= IDLE;
                    end else if (done) begin
                        state_q   <= IDLE;
                        dstreak_q <= dstreak_inc_d;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-by-cycle vector table for mem_arbiter (MAX_DSTREAK=4,
// TIMEOUT=8). Each record holds the inputs for one cycle and the outputs
// expected in that cycle, worked out by hand from the arbitration rules.
// Asynchronous reset behaviour is covered by hand-written sequences.
module tb_mem_arbiter;

    localparam int RS_F = 0;
    localparam int RS_B = 1;
    localparam int RS_A = 2;
    localparam int RS_E = 3;
    localparam logic [31:0] IA = 32'h0000_0040;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] LD = 32'h2402_000A;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        i, dr, dw;
        logic [1:0]  rs;
        logic [31:0] da, rl;
        logic        ren, wen;
        logic [31:0] ra, rst, il, dl;
        logic        iw, dwt, me;
    } vec_t;

    vec_t vq[$];
    int   tests;
    int   fails;

    task automatic add(input int i, input int dr, input int dw, input int rs,
                       input logic [31:0] da, input logic [31:0] rl,
                       input int ren, input int wen,
                       input logic [31:0] ra, input logic [31:0] rst,
                       input int iw, input int dwt,
                       input logic [31:0] il, input logic [31:0] dl,
                       input int me);
        vec_t v;
        v.i = i[0];   v.dr = dr[0];  v.dw = dw[0];  v.rs = rs[1:0];
        v.da = da;    v.rl = rl;
        v.ren = ren[0]; v.wen = wen[0];
        v.ra = ra;    v.rst = rst;   v.il = il;     v.dl = dl;
        v.iw = iw[0]; v.dwt = dwt[0]; v.me = me[0];
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end else begin
            $display("[TB] %s ok (%h)", name, act);
        end
    endtask

    task automatic idle_rows();
        add(0,0,0,RS_F, 0,0, 0,0, 0,0, 0,0, 0,0, 0);
    endtask

    logic [132:0] act_v;
    logic [132:0] exp_v;

    initial begin
        tests = 0;
        fails = 0;
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = IA; daddr = '0; dstore = DB; ramload = '0; ramstate = 2'd0;

        // ---- vector table ------------------------------------------------
        // fetch only: 2 BUSY then ACCESS
        add(1,0,0,RS_F, 0,0,           0,0, 0,0,  1,0, 0,0, 0);
        add(1,0,0,RS_B, 0,0,           1,0, IA,0, 1,0, 0,0, 0);
        add(1,0,0,RS_B, 0,0,           1,0, IA,0, 1,0, 0,0, 0);
        add(1,0,0,RS_A, 0,LD,          1,0, IA,0, 0,0, LD,0, 0);
        idle_rows();
        // contention: data first, fetch after
        add(1,1,0,RS_F, 'h100,0,         0,0, 0,0,      1,1, 0,0, 0);
        add(1,1,0,RS_B, 'h100,0,         1,0, 'h100,0,  1,1, 0,0, 0);
        add(1,1,0,RS_A, 'h100,'h11111111, 1,0, 'h100,0, 1,0, 0,'h11111111, 0);
        add(1,0,0,RS_F, 'h100,0,         0,0, 0,0,      1,0, 0,0, 0);
        add(1,0,0,RS_A, 0,LD,            1,0, IA,0,     0,0, LD,0, 0);
        // starvation bound: four data grants, then forced fetch, then data
        for (int k = 0; k < 4; k++) begin
            add(1,1,0,RS_F, 'h100 + 4*k, 0,         0,0, 0,0,           1,1, 0,0, 0);
            add(1,1,0,RS_A, 'h100 + 4*k, 'hA0 + k,  1,0, 'h100 + 4*k,0, 1,0, 0,'hA0 + k, 0);
        end
        add(1,1,0,RS_F, 'h110,0,      0,0, 0,0,      1,1, 0,0, 0);
        add(1,1,0,RS_A, 'h110,'hC0DE, 1,0, IA,0,     0,1, 'hC0DE,0, 0);
        add(1,1,0,RS_F, 'h110,0,      0,0, 0,0,      1,1, 0,0, 0);
        add(1,1,0,RS_A, 'h110,'hB1,   1,0, 'h110,0,  1,0, 0,'hB1, 0);
        idle_rows();
        // write over read
        add(0,1,1,RS_F, 'h200,0,    0,0, 0,0,       0,1, 0,0, 0);
        add(0,1,1,RS_B, 'h200,0,    0,1, 'h200,DB,  0,1, 0,0, 0);
        add(0,1,1,RS_A, 'h200,'h55, 0,1, 'h200,DB,  0,0, 0,0, 0);
        idle_rows();
        // RAM error on a data read
        add(0,1,0,RS_F, 'h300,0,    0,0, 0,0,       0,1, 0,0, 0);
        add(0,1,0,RS_E, 'h300,'h77, 1,0, 'h300,0,   0,0, 0,0, 1);
        idle_rows();
        // data request dropped mid-grant (streak stays at 3)
        add(0,1,0,RS_F, 'h400,0,    0,0, 0,0,       0,1, 0,0, 0);
        add(0,1,0,RS_B, 'h400,0,    1,0, 'h400,0,   0,1, 0,0, 0);
        add(0,0,0,RS_B, 'h400,0,    0,0, 0,0,       0,0, 0,0, 0);
        idle_rows();
        // streak 3: one more data grant, then fetch is forced
        add(1,1,0,RS_F, 'h500,0,    0,0, 0,0,       1,1, 0,0, 0);
        add(1,1,0,RS_A, 'h500,'h99, 1,0, 'h500,0,   1,0, 0,'h99, 0);
        add(1,1,0,RS_F, 'h500,0,    0,0, 0,0,       1,1, 0,0, 0);
        add(1,1,0,RS_A, 'h500,'hAB, 1,0, IA,0,      0,1, 'hAB,0, 0);
        idle_rows();
        // timeout: 8th BUSY grant cycle aborts, next grant restarts the count
        add(0,1,0,RS_F, 'h600,0,    0,0, 0,0,       0,1, 0,0, 0);
        for (int k = 0; k < 7; k++) begin
            add(0,1,0,RS_B, 'h600,0, 1,0, 'h600,0,  0,1, 0,0, 0);
        end
        add(0,1,0,RS_B, 'h600,0,    1,0, 'h600,0,   0,0, 0,0, 1);
        add(0,1,0,RS_F, 'h600,0,    0,0, 0,0,       0,1, 0,0, 0);
        add(0,1,0,RS_B, 'h600,0,    1,0, 'h600,0,   0,1, 0,0, 0);
        idle_rows();
        idle_rows();

        // ---- reset state ---------------------------------------------------
        #12;
        iREN = 1'b1; dREN = 1'b1; ramstate = 2'd2; ramload = LD;
        #1;
        chk("reset_ram", {30'd0, ramREN, ramWEN} | ramaddr | ramstore, 32'd0);
        chk("reset_wait", {29'd0, iwait, dwait, memerr}, 32'h6);
        chk("reset_load", iload | dload, 32'd0);
        iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0; ramload = '0;
        @(negedge CLK);
        nRST = 1'b1;

        // ---- apply table ---------------------------------------------------
        for (int n = 0; n < vq.size(); n++) begin
            @(posedge CLK);
            #1;
            iREN = vq[n].i; dREN = vq[n].dr; dWEN = vq[n].dw;
            ramstate = vq[n].rs; daddr = vq[n].da; ramload = vq[n].rl;
            @(negedge CLK);
            act_v = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, memerr};
            exp_v = {vq[n].ren, vq[n].wen, vq[n].ra, vq[n].rst, vq[n].iw, vq[n].dwt,
                     vq[n].il, vq[n].dl, vq[n].me};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL vec%0d: got %h, want %h", n, act_v, exp_v);
            end else begin
                $display("[TB] vec%0d ok", n);
            end
        end

        // ---- reset asserted mid-IGRANT ---------------------------------------
        @(posedge CLK);
        #1;
        iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd1;
        @(posedge CLK);
        @(negedge CLK);
        chk("igrant_before_reset", {31'd0, ramREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_reset_ren", {31'd0, ramREN}, 32'd0);
        chk("async_reset_addr", ramaddr, 32'd0);
        chk("async_reset_iwait", {31'd0, iwait}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        chk("held_reset_ren", {31'd0, ramREN}, 32'd0);
        nRST = 1'b1;
        #1;
        chk("post_reset_idle", {31'd0, ramREN}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("post_reset_regrant", ramaddr, IA);
        iREN = 1'b0;
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
